register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//   Parametrised multi-read-port integer register file with a pending-write scoreboard.
//   Sits between decode/issue and the ALU/writeback stages of the core.
//   Reset does not clear the array in one cycle: a clear sequencer walks it one entry per cycle.
//   oREADY gates the pipeline until the walk completes.
// PARAMETERS
//   XLEN      32  data width of each register
//   DEPTH     32  number of registers (power of 2, >=2)
//   NREAD     3   number of combinational read ports
//   ZERO_REG  1   1: entry 0 is hardwired to zero, never written, never busy
//   AW        $clog2(DEPTH)  address width (localparam, derived)
// PORTS
//   iCLK           in   1           clock; all state updates on posedge
//   iRST           in   1           synchronous, active-high reset
//   oREADY         out  1           1 = clear walk finished, array usable
//   iRS            in   NREAD*AW    read addresses; port k = iRS[k*AW +: AW]
//   oRDATA         out  NREAD*XLEN  read data; port k = oRDATA[k*XLEN +: XLEN]
//   oRS_BUSY       out  NREAD       port k: register iRS[k] has a pending write
//   iWE            in   1           writeback enable
//   iRD            in   AW          writeback address
//   iWDATA         in   XLEN        writeback data
//   iISSUE         in   1           an instruction issued that will write iISSUE_RD
//   iISSUE_RD      in   AW          destination of the issuing instruction
// BEHAVIOUR
//   - Reset and clear:
//     - iRST=1 at a posedge: FSM -> CLEAR, clear pointer=0, every busy bit=0, oREADY=0.
//     - CLEAR: one entry per cycle, regfile[ptr]<=0, ptr++.
//     - Entering READY: after the write of entry DEPTH-1 (DEPTH cycles after reset is released), oREADY=1.
//     - iRST asserted again mid-CLEAR restarts at ptr=0.
//   - Outputs while oREADY=0:
//     - oRDATA all zeros, oRS_BUSY all zeros.
//     - iWE and iISSUE are ignored.
//   - FSM states: CLEAR, READY. READY is left only via iRST.
//   - Reads (READY): combinational.
//     - oRDATA[k] = regfile[iRS[k]].
//     - With ZERO_REG=1: address 0 reads 0 regardless of array contents.
//   - Write (READY): at posedge, if iWE and !(ZERO_REG && iRD==0), regfile[iRD]<=iWDATA.
//     - Write data is visible on reads from the next cycle, unless the bypass feature is compiled in.
//   - Scoreboard (READY), one busy bit per entry:
//     - iISSUE sets busy[iISSUE_RD].
//     - iWE clears busy[iRD].
//     - Same address and same cycle: set wins, so busy stays 1 (back-to-back WAW).
//     - Different addresses: both take effect.
//     - ZERO_REG=1: busy[0] is never set.
//     - oRS_BUSY[k] = busy[iRS[k]], taken from registered state. A same-cycle iISSUE is not reflected.
//   - Widths: iRD/iISSUE_RD >= DEPTH cannot occur (AW exact); no truncation or extension of data.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - When READY and iWE and iRD==iRS[k] (and not the zero register), oRDATA[k]=iWDATA in the same cycle.
//     - oRS_BUSY[k] is forced to 0 in that cycle.
//   REGFILE_BYPASS_EN undefined:
//     - Reads return the old array value during a same-cycle write.
//     - oRS_BUSY[k] reflects the registered busy bit.
// TESTING
//   1. Release iRST -> oREADY=0 for exactly 32 cycles, then 1; reads of x1..x31 return 0.
//   2. Mid-clear reset:
//      - Assert iRST for 1 cycle after 10 clear cycles -> oREADY stays 0 for 32 more cycles after release.
//      - Meanwhile iWE to x5 is ignored (x5 reads 0 after ready).
//   3. Write/read:
//      - Write x7=0xDEADBEEF, then read x7 on all 3 ports next cycle -> 0xDEADBEEF.
//      - Write x0=0x1234 -> x0 reads 0.
//   4. Scoreboard:
//      - Issue x9 -> next cycle oRS_BUSY=1 on the port reading x9.
//      - iWE x9 -> busy clears the cycle after.
//      - Issue and write x9 in the same cycle -> busy stays 1.
//   5. Bypass:
//      - Same-cycle iWE x3=0xA5A5A5A5 with iRS[0]=3.
//      - REGFILE_BYPASS_EN defined -> oRDATA[0]=0xA5A5A5A5 in that cycle.
//      - REGFILE_BYPASS_EN undefined -> old value in that cycle, new value the next cycle.
//   6. Params DEPTH=16, NREAD=2, ZERO_REG=0:
//      - Clear takes 16 cycles.
//      - Write x0=0x55 -> x0 reads 0x55.

Source files
------------

// File: rtl/register_file_mp_if.sv
// Bus between decode/issue, writeback and register_file_mp: read ports,
// writeback port, issue-side scoreboard update and the ready flag.
interface register_file_mp_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 3
);
  localparam int AW = $clog2(DEPTH);

  logic                  oREADY;
  logic [NREAD*AW-1:0]   iRS;
  logic [NREAD*XLEN-1:0] oRDATA;
  logic [NREAD-1:0]      oRS_BUSY;
  logic                  iWE;
  logic [AW-1:0]         iRD;
  logic [XLEN-1:0]       iWDATA;
  logic                  iISSUE;
  logic [AW-1:0]         iISSUE_RD;

  modport master (
    input  oREADY, oRDATA, oRS_BUSY,
    output iRS, iWE, iRD, iWDATA, iISSUE, iISSUE_RD
  );

  modport slave (
    output oREADY, oRDATA, oRS_BUSY,
    input  iRS, iWE, iRD, iWDATA, iISSUE, iISSUE_RD
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-read-port register file with pending-write scoreboard and a clear walk after reset.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
//
// state | meaning
// CLEAR | walking the array, one entry zeroed per cycle; bus inputs ignored
// READY | array usable; reads, writes and scoreboard updates active
module register_file_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 3,
  parameter int ZERO_REG = 1
) (
  input logic               iCLK,
  input logic               iRST,
  register_file_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state, stateNext;
  logic [AW-1:0]    clrPtr;
  logic [XLEN-1:0]  regs [DEPTH];
  logic [DEPTH-1:0] busy, busyNext;
  logic             isReady;
  logic             wrEn;
  logic             issueEn;

  assign isReady    = (state == READY);
  assign bus.oREADY = isReady;
  assign wrEn       = isReady && bus.iWE && !(ZERO_REG != 0 && bus.iRD == '0);
  assign issueEn    = isReady && bus.iISSUE && !(ZERO_REG != 0 && bus.iISSUE_RD == '0);

  always_ff @(posedge iCLK) begin
    if (iRST) state <= CLEAR;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (state == CLEAR && clrPtr == AW'(DEPTH - 1)) stateNext = READY;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      clrPtr <= '0;
    end else if (state == CLEAR) begin
      regs[clrPtr] <= '0;
      clrPtr       <= clrPtr + 1'b1;
    end else if (wrEn) begin
      regs[bus.iRD] <= bus.iWDATA;
    end
  end

  // Issue is applied after writeback so a same-entry collision leaves the bit set.
  always_comb begin
    busyNext = busy;
    if (wrEn)    busyNext[bus.iRD]       = 1'b0;
    if (issueEn) busyNext[bus.iISSUE_RD] = 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) busy <= '0;
    else      busy <= busyNext;
  end

  always_comb begin
    bus.oRDATA   = '0;
    bus.oRS_BUSY = '0;
    for (int k = 0; k < NREAD; k++) begin
      logic [AW-1:0] rsAddr;
      rsAddr = bus.iRS[k*AW +: AW];
      if (isReady && !(ZERO_REG != 0 && rsAddr == '0)) begin
        bus.oRDATA[k*XLEN +: XLEN] = regs[rsAddr];
        bus.oRS_BUSY[k]            = busy[rsAddr];
`ifdef REGFILE_BYPASS_EN
        if (wrEn && bus.iRD == rsAddr) begin
          bus.oRDATA[k*XLEN +: XLEN] = bus.iWDATA;
          bus.oRS_BUSY[k]            = 1'b0;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default instance plus a DEPTH=16, NREAD=2,
// ZERO_REG=0 instance sharing clock and reset.
module tb_register_file_mp;
  logic iCLK = 1'b0;
  logic iRST;
  int   nChecks = 0;
  int   nErrors = 0;
  int   rdy1At, rdy2At;
  logic [31:0] expData;
  logic        expBusy;

  always #5 iCLK = ~iCLK;

  register_file_mp_if #(.XLEN(32), .DEPTH(32), .NREAD(3)) bus1 ();
  register_file_mp_if #(.XLEN(32), .DEPTH(16), .NREAD(2)) bus2 ();

  register_file_mp #(.XLEN(32), .DEPTH(32), .NREAD(3), .ZERO_REG(1)) dut1 (
    .iCLK(iCLK), .iRST(iRST), .bus(bus1)
  );
  register_file_mp #(.XLEN(32), .DEPTH(16), .NREAD(2), .ZERO_REG(0)) dut2 (
    .iCLK(iCLK), .iRST(iRST), .bus(bus2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle();
    bus1.iWE = 1'b0; bus1.iRD = '0; bus1.iWDATA = '0; bus1.iISSUE = 1'b0; bus1.iISSUE_RD = '0;
    bus2.iWE = 1'b0; bus2.iRD = '0; bus2.iWDATA = '0; bus2.iISSUE = 1'b0; bus2.iISSUE_RD = '0;
  endtask

  task automatic countReady();
    rdy1At = 0;
    rdy2At = 0;
    for (int n = 1; n <= 40; n++) begin
      bus1.iWE       = (n >= 15 && n < 20);
      bus1.iRD       = 5'd5;
      bus1.iWDATA    = 32'hCAFE_0005;
      bus1.iISSUE    = (n >= 15 && n < 20);
      bus1.iISSUE_RD = 5'd6;
      tick();
      #1;
      if (bus1.oREADY && rdy1At == 0) rdy1At = n;
      if (bus2.oREADY && rdy2At == 0) rdy2At = n;
    end
    idle();
  endtask

  initial begin
    iRST = 1'b1;
    idle();
    bus1.iRS = {5'd3, 5'd2, 5'd1};
    bus2.iRS = {4'd1, 4'd0};
    tick();
    tick();
    #1;
    check("reset_ready1", bus1.oREADY, 0);
    check("reset_ready2", bus2.oREADY, 0);
    check("reset_busy1", bus1.oRS_BUSY, 0);
    check("reset_rdata1", bus1.oRDATA, 0);

    // Release reset and time the clear walk on both instances
    iRST = 1'b0;
    countReady();
    check("clear_len32", rdy1At, 32);
    check("clear_len16", rdy2At, 16);
    for (int i = 1; i < 32; i++) begin
      bus1.iRS = {3{5'(i)}};
      #1;
      check("clear_read", bus1.oRDATA[(i%3)*32 +: 32], 0);
    end

    // Mid-clear reset restarts the walk; writes/issues during the walk are dropped
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    iRST = 1'b1;
    tick();
    #1;
    check("midclr_ready", bus1.oREADY, 0);
    iRST = 1'b0;
    countReady();
    check("midclr_len32", rdy1At, 32);
    check("midclr_len16", rdy2At, 16);
    bus1.iRS = {5'd6, 5'd5, 5'd5};
    #1;
    check("midclr_x5", bus1.oRDATA[31:0], 0);
    check("midclr_busy_x6", bus1.oRS_BUSY[2], 0);

    // Write/read, zero register on both instances
    bus1.iWE = 1'b1; bus1.iRD = 5'd7; bus1.iWDATA = 32'hDEAD_BEEF;
    tick();
    idle();
    bus1.iRS = {3{5'd7}};
    #1;
    check("rd_x7_p0", bus1.oRDATA[31:0], 32'hDEAD_BEEF);
    check("rd_x7_p1", bus1.oRDATA[63:32], 32'hDEAD_BEEF);
    check("rd_x7_p2", bus1.oRDATA[95:64], 32'hDEAD_BEEF);
    bus1.iWE = 1'b1; bus1.iRD = 5'd0; bus1.iWDATA = 32'h1234;
    bus2.iWE = 1'b1; bus2.iRD = 4'd0; bus2.iWDATA = 32'h55;
    tick();
    idle();
    bus1.iRS = {5'd7, 5'd7, 5'd0};
    bus2.iRS = {4'd1, 4'd0};
    #1;
    check("rd_x0_zero", bus1.oRDATA[31:0], 0);
    check("rd_x0_nozero", bus2.oRDATA[31:0], 32'h55);

    // Scoreboard
    bus1.iISSUE = 1'b1; bus1.iISSUE_RD = 5'd9;
    bus1.iRS = {5'd9, 5'd9, 5'd7};
    #1;
    check("sb_same_cycle", bus1.oRS_BUSY[1], 0);
    tick();
    idle();
    #1;
    check("sb_issue_x9", bus1.oRS_BUSY[1], 1);
    check("sb_other_x7", bus1.oRS_BUSY[0], 0);
    bus1.iWE = 1'b1; bus1.iRD = 5'd9; bus1.iWDATA = 32'h99;
    tick();
    idle();
    #1;
    check("sb_wb_clear", bus1.oRS_BUSY[1], 0);
    check("sb_wb_data", bus1.oRDATA[63:32], 32'h99);
    bus1.iWE = 1'b1; bus1.iRD = 5'd9; bus1.iWDATA = 32'h98;
    bus1.iISSUE = 1'b1; bus1.iISSUE_RD = 5'd9;
    tick();
    idle();
    #1;
    check("sb_waw", bus1.oRS_BUSY[1], 1);
    bus1.iWE = 1'b1; bus1.iRD = 5'd9; bus1.iWDATA = 32'h9A;
    bus1.iISSUE = 1'b1; bus1.iISSUE_RD = 5'd10;
    tick();
    idle();
    bus1.iRS = {5'd10, 5'd9, 5'd7};
    #1;
    check("sb_diff_set", bus1.oRS_BUSY[2], 1);
    check("sb_diff_clr", bus1.oRS_BUSY[1], 0);
    bus1.iISSUE = 1'b1; bus1.iISSUE_RD = 5'd0;
    bus2.iISSUE = 1'b1; bus2.iISSUE_RD = 4'd0;
    tick();
    idle();
    bus1.iRS = {5'd10, 5'd9, 5'd0};
    #1;
    check("sb_x0_zero", bus1.oRS_BUSY[0], 0);
    check("sb_x0_nozero", bus2.oRS_BUSY[0], 1);

    // Same-cycle write vs read of x3
    bus1.iWE = 1'b1; bus1.iRD = 5'd3; bus1.iWDATA = 32'h1111_1111;
    bus1.iISSUE = 1'b1; bus1.iISSUE_RD = 5'd3;
    tick();
    idle();
    bus1.iRS = {5'd10, 5'd7, 5'd3};
    #1;
    check("byp_pre_data", bus1.oRDATA[31:0], 32'h1111_1111);
    check("byp_pre_busy", bus1.oRS_BUSY[0], 1);
    bus1.iWE = 1'b1; bus1.iRD = 5'd3; bus1.iWDATA = 32'hA5A5_A5A5;
`ifdef REGFILE_BYPASS_EN
    expData = 32'hA5A5_A5A5;
    expBusy = 1'b0;
`else
    expData = 32'h1111_1111;
    expBusy = 1'b1;
`endif
    #1;
    check("byp_same_data", bus1.oRDATA[31:0], expData);
    check("byp_same_busy", bus1.oRS_BUSY[0], expBusy);
    tick();
    idle();
    #1;
    check("byp_next_data", bus1.oRDATA[31:0], 32'hA5A5_A5A5);
    check("byp_next_busy", bus1.oRS_BUSY[0], 0);

    // Reset from READY drops ready, busy and read data
    iRST = 1'b1;
    tick();
    #1;
    check("rerst_ready", bus1.oREADY, 0);
    check("rerst_busy", bus1.oRS_BUSY, 0);
    check("rerst_rdata", bus1.oRDATA, 0);
    iRST = 1'b0;

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
